alu_mdu: RTL and testbench

Parametrised multi-cycle ALU for the MIPS CPU datapath, successor to the single-cycle execute-stage ALU. It keeps the existing 4-bit operation encoding and adds SUB, SLT, a variable shift, and iterative unsigned multiply/divide with HI/LO registers. All results are registered, and a start/busy/done handshake lets the pipeline control stall the execute stage during long operations.

---
 rtl/alu_mdu_pkg.sv | 27 ++
 rtl/alu_mdu_if.sv | 28 ++
 rtl/alu_mdu_iter.sv | 67 ++++++
 rtl/alu_mdu.sv | 147 ++++++++++++++
 tb/tb_alu_mdu.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the multi-cycle MIPS ALU: opcodes, FSM states, default width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_ANDI  = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// Execute-stage request/result bundle between pipeline control (master) and the ALU (slave).
interface alu_mdu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [3:0]       control_in;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, control_in, in1, in2,
        input  out, zero, overflow, busy, done
    );

    modport slave (
        input  start, control_in, in1, in2,
        output out, zero, overflow, busy, done
    );

endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative datapath: one shift-add (MULTU) or restoring shift-subtract (DIVU) step per strobe.
// The next {hi,lo} is exposed combinationally so the final step can be captured by the parent directly.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] opA_i,
    input  logic [WIDTH-1:0] opB_i,
    output logic [WIDTH-1:0] hiNext_o,
    output logic [WIDTH-1:0] loNext_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   trial;

    // low_q holds the multiplier (shifting out LSB-first) or the dividend/quotient (shifting MSB-first)
    always_comb begin
        acc_d    = acc_q;
        low_d    = low_q;
        sum      = '0;
        remShift = '0;
        trial    = '0;
        if (div_i) begin
            remShift = {acc_q, low_q[WIDTH-1]};
            trial    = remShift - {1'b0, opB_q};
            if (!trial[WIDTH]) begin
                acc_d = trial[WIDTH-1:0];
                low_d = {low_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = remShift[WIDTH-1:0];
                low_d = {low_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum            = {1'b0, acc_q} + (low_q[0] ? {1'b0, opB_q} : '0);
            {acc_d, low_d} = {sum, low_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            low_q <= '0;
            opB_q <= '0;
        end else if (load_i) begin
            acc_q <= '0;
            low_q <= opA_i;
            opB_q <= opB_i;
        end else if (step_i) begin
            acc_q <= acc_d;
            low_q <= low_d;
        end
    end

    assign hiNext_o = acc_d;
    assign loNext_o = low_d;

endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle MIPS ALU: single-cycle ops, iterative MULTU/DIVU with HI/LO, start/busy/done handshake.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    alu_mdu_if.slave bus
);

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             iterLoad, iterStep;
    logic [WIDTH-1:0] iterHi, iterLo;
    logic [WIDTH-1:0] addB, sumRes, aluResult;
    logic             aluOvf;

    // SUB reuses the adder with a two's-complement operand so overflow has one formula
    always_comb begin
        addB      = (bus.control_in == OP_SUB) ? (~bus.in2 + 1'b1) : bus.in2;
        sumRes    = bus.in1 + addB;
        aluResult = '0;
        aluOvf    = 1'b0;
        case (bus.control_in)
            OP_ADD, OP_ADDI, OP_SUB: begin
                aluResult = sumRes;
                aluOvf    = (bus.in1[WIDTH-1] == addB[WIDTH-1]) &&
                            (sumRes[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_LW, OP_SW:    aluResult = sumRes;
            OP_SLL:          aluResult = bus.in1 << bus.in2[SHW-1:0];
            OP_AND, OP_ANDI: aluResult = bus.in1 & bus.in2;
            OP_NOR:          aluResult = ~(bus.in1 | bus.in2);
            OP_SLT:          aluResult = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
            OP_MFHI:         aluResult = hi_q;
            OP_MFLO:         aluResult = lo_q;
            default:         aluResult = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        out_d    = out_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        iterLoad = 1'b0;
        iterStep = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.control_in == OP_MULTU) begin
                        iterLoad = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else if (bus.control_in == OP_DIVU && bus.in2 != '0) begin
                        iterLoad = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_DIV;
                    end else if (bus.control_in == OP_DIVU) begin
                        hi_d   = bus.in1;
                        lo_d   = '1;
                        out_d  = '1;
                        zero_d = 1'b0;
                        ovf_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        out_d  = aluResult;
                        zero_d = (aluResult == '0);
                        ovf_d  = aluOvf;
                        done_d = 1'b1;
                    end
                end
            end
            S_MUL, S_DIV: begin
                iterStep = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    hi_d    = iterHi;
                    lo_d    = iterLo;
                    out_d   = iterLo;
                    zero_d  = (iterLo == '0);
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (iterLoad),
        .step_i   (iterStep),
        .div_i    (state_q == S_DIV),
        .opA_i    (bus.in1),
        .opB_i    (bus.in2),
        .hiNext_o (iterHi),
        .loNext_o (iterLo)
    );

    assign bus.out      = out_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected results queued at issue, compared on each done pulse.
module tb_alu_mdu;
    import alu_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] out;
        logic        zero;
        logic        ovf;
    } expEntry_t;

    logic clk;
    logic rst;

    alu_mdu_if #(.WIDTH(32)) busA ();
    alu_mdu_if #(.WIDTH(8))  busB ();

    alu_mdu #(.WIDTH(32)) dutA (.clk(clk), .rst(rst), .bus(busA));
    alu_mdu #(.WIDTH(8))  dutB (.clk(clk), .rst(rst), .bus(busB));

    expEntry_t   sbA[$];
    expEntry_t   popA;
    logic [31:0] mHi, mLo;
    int          checkCount = 0;
    int          passCount  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Reference model: wide arithmetic, overflow from a 33-bit sign-extended sum
    function automatic expEntry_t modelOp(input string tag, input logic [3:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        expEntry_t   e;
        logic [32:0] wide;
        logic [31:0] bNeg;
        logic [63:0] prod;
        e.tag = tag;
        e.out = '0;
        e.ovf = 1'b0;
        bNeg  = 32'd0 - b;
        case (op)
            OP_ADD, OP_ADDI: begin
                wide  = {a[31], a} + {b[31], b};
                e.out = wide[31:0];
                e.ovf = wide[32] ^ wide[31];
            end
            OP_SUB: begin
                wide  = {a[31], a} + {bNeg[31], bNeg};
                e.out = wide[31:0];
                e.ovf = wide[32] ^ wide[31];
            end
            OP_LW, OP_SW:    e.out = a + b;
            OP_SLL:          e.out = a << b[4:0];
            OP_AND, OP_ANDI: e.out = a & b;
            OP_NOR:          e.out = ~(a | b);
            OP_SLT:          e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_MULTU: begin
                prod  = {32'd0, a} * {32'd0, b};
                mHi   = prod[63:32];
                mLo   = prod[31:0];
                e.out = mLo;
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    mHi = a;
                    mLo = 32'hFFFF_FFFF;
                end else begin
                    mHi = a % b;
                    mLo = a / b;
                end
                e.out = mLo;
            end
            OP_MFHI: e.out = mHi;
            OP_MFLO: e.out = mLo;
            default: e.out = '0;
        endcase
        e.zero = (e.out == 32'd0);
        return e;
    endfunction

    // Drives one request for one cycle and leaves start high so calls can run back-to-back
    task automatic applyStimulus(input string tag, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        sbA.push_back(modelOp(tag, op, a, b));
        busA.start      = 1'b1;
        busA.control_in = op;
        busA.in1        = a;
        busA.in2        = b;
        @(negedge clk);
    endtask

    task automatic idleBus();
        busA.start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int expBusy);
        int busyCycles = 0;
        int guard      = 0;
        while (!busA.done && guard < 200) begin
            if (busA.busy) busyCycles++;
            guard++;
            @(negedge clk);
        end
        checkOutput({tag, "_done"}, 64'(busA.done), 64'd1);
        checkOutput({tag, "_busyCycles"}, 64'(busyCycles), 64'(expBusy));
        checkOutput({tag, "_busyDoneExcl"}, 64'(busA.busy), 64'd0);
    endtask

    always @(negedge clk) begin
        if (busA.done) begin
            if (sbA.size() == 0) begin
                checkOutput("sb_unexpectedDone", 64'd1, 64'd0);
            end else begin
                popA = sbA.pop_front();
                checkOutput({popA.tag, "_out"}, 64'(busA.out), 64'(popA.out));
                checkOutput({popA.tag, "_zero"}, 64'(busA.zero), 64'(popA.zero));
                checkOutput({popA.tag, "_ovf"}, 64'(busA.overflow), 64'(popA.ovf));
            end
        end
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int          doneSeen;
        int          guard;
        int          busyCycles;

        rst             = 1'b1;
        busA.start      = 1'b0;
        busA.control_in = '0;
        busA.in1        = '0;
        busA.in2        = '0;
        busB.start      = 1'b0;
        busB.control_in = '0;
        busB.in1        = '0;
        busB.in2        = '0;
        mHi             = '0;
        mLo             = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out", 64'(busA.out), 64'd0);
        checkOutput("rst_zero", 64'(busA.zero), 64'd0);
        checkOutput("rst_ovf", 64'(busA.overflow), 64'd0);
        checkOutput("rst_busy", 64'(busA.busy), 64'd0);
        checkOutput("rst_done", 64'(busA.done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single-cycle ops");
        applyStimulus("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1);
        checkOutput("add_latency", 64'(busA.done), 64'd1);
        idleBus();
        @(negedge clk);
        checkOutput("done_pulseWidth", 64'(busA.done), 64'd0);

        applyStimulus("sub_zero", OP_SUB, 32'd5, 32'd5);
        applyStimulus("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1);
        applyStimulus("nor_zero", OP_NOR, 32'd0, 32'd0);
        applyStimulus("addi_wrap", OP_ADDI, 32'hFFFF_FFF0, 32'h10);
        applyStimulus("lw_addr", OP_LW, 32'h1000, 32'h24);
        applyStimulus("sw_noOvf", OP_SW, 32'h8000_0000, 32'h8000_0000);
        applyStimulus("sll_mask", OP_SLL, 32'd1, 32'h23);
        applyStimulus("sll_max", OP_SLL, 32'h3, 32'd31);
        applyStimulus("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        applyStimulus("andi", OP_ANDI, 32'h1234_5678, 32'h0000_FFFF);
        applyStimulus("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1);
        applyStimulus("slt_pos", OP_SLT, 32'd1, 32'hFFFF_FFFF);
        applyStimulus("rsvd_e", 4'b1110, 32'hDEAD_BEEF, 32'h1);
        applyStimulus("rsvd_f", 4'b1111, 32'hDEAD_BEEF, 32'h1);
        idleBus();
        @(negedge clk);

        $display("[TB] MULTU then MFHI/MFLO");
        applyStimulus("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        idleBus();
        waitDone("multu", 32);
        applyStimulus("mfhi_mul", OP_MFHI, 32'd0, 32'd0);
        applyStimulus("mflo_mul", OP_MFLO, 32'd0, 32'd0);
        idleBus();
        @(negedge clk);

        $display("[TB] DIVU with ignored mid-busy start");
        applyStimulus("divu", OP_DIVU, 32'd100, 32'd7);
        idleBus();
        repeat (5) @(negedge clk);
        busA.start      = 1'b1;
        busA.control_in = OP_ADD;
        busA.in1        = 32'd1;
        busA.in2        = 32'd1;
        @(negedge clk);
        busA.start = 1'b0;
        waitDone("divu", 26);
        applyStimulus("mfhi_div", OP_MFHI, 32'd0, 32'd0);
        applyStimulus("mflo_div", OP_MFLO, 32'd0, 32'd0);
        idleBus();
        @(negedge clk);

        $display("[TB] divide by zero");
        applyStimulus("div0", OP_DIVU, 32'd9, 32'd0);
        checkOutput("div0_latency", 64'(busA.done), 64'd1);
        checkOutput("div0_busy", 64'(busA.busy), 64'd0);
        applyStimulus("mfhi_div0", OP_MFHI, 32'd0, 32'd0);
        idleBus();
        @(negedge clk);

        $display("[TB] random MULTU/DIVU");
        for (int i = 0; i < 2; i++) begin
            ra = $urandom();
            rb = $urandom();
            applyStimulus("rnd_mul", OP_MULTU, ra, rb);
            idleBus();
            waitDone("rnd_mul", 32);
            applyStimulus("rnd_mulHi", OP_MFHI, 32'd0, 32'd0);
            idleBus();
            @(negedge clk);
            rb = ($urandom() >> (i * 12)) | 32'd1;
            applyStimulus("rnd_div", OP_DIVU, ra, rb);
            idleBus();
            waitDone("rnd_div", 32);
            applyStimulus("rnd_divHi", OP_MFHI, 32'd0, 32'd0);
            idleBus();
            @(negedge clk);
        end

        $display("[TB] reset mid-MULTU");
        applyStimulus("rst_mul", OP_MULTU, 32'h1234, 32'h5678);
        idleBus();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        void'(sbA.pop_back());
        mHi = '0;
        mLo = '0;
        @(negedge clk);
        checkOutput("midRst_busy", 64'(busA.busy), 64'd0);
        checkOutput("midRst_out", 64'(busA.out), 64'd0);
        checkOutput("midRst_done", 64'(busA.done), 64'd0);
        rst      = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (busA.done) doneSeen++;
        end
        checkOutput("midRst_noDone", 64'(doneSeen), 64'd0);
        applyStimulus("midRst_mflo", OP_MFLO, 32'd0, 32'd0);
        idleBus();
        @(negedge clk);

        $display("[TB] WIDTH=8 MULTU");
        busB.start      = 1'b1;
        busB.control_in = OP_MULTU;
        busB.in1        = 8'd200;
        busB.in2        = 8'd3;
        @(negedge clk);
        busB.start = 1'b0;
        busyCycles = 0;
        guard      = 0;
        while (!busB.done && guard < 100) begin
            if (busB.busy) busyCycles++;
            guard++;
            @(negedge clk);
        end
        checkOutput("w8_done", 64'(busB.done), 64'd1);
        checkOutput("w8_busyCycles", 64'(busyCycles), 64'd8);
        checkOutput("w8_lo", 64'(busB.out), 64'h58);
        busB.start      = 1'b1;
        busB.control_in = OP_MFHI;
        @(negedge clk);
        busB.start = 1'b0;
        checkOutput("w8_hi", 64'(busB.out), 64'h02);
        @(negedge clk);

        checkOutput("sb_drained", 64'(sbA.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
